// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and helpers.
// The receive core uses them today; the transmit core will import the same package.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // sclk cycles per bit; integer division, so the line rate rounds slightly fast
  function automatic int baud_cnt_calc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // 2-of-3 majority used to vote each bit from three adjacent samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_baud_tick.sv
// Bit-period timer shared by the UART cores: counts 0..BAUD_CNT-1 and flags the
// three mid-bit sample points and the end of the bit.
module uart_baud_tick #(
  parameter int BAUD_CNT = 434
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic clr,
  output logic smp_m1,
  output logic smp_mid,
  output logic smp_p1,
  output logic bit_end
);

  localparam int CW  = $clog2(BAUD_CNT);
  localparam int MID = BAUD_CNT / 2;

  logic [CW-1:0] cnt;

  // free-running bit counter; clr realigns it to the detected start edge
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign smp_m1  = (cnt == CW'(MID - 1));
  assign smp_mid = (cnt == CW'(MID));
  assign smp_p1  = (cnt == CW'(MID + 1));
  assign bit_end = (cnt == CW'(BAUD_CNT - 1));

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: synchroniser, start detect, 3-sample majority
// vote per bit, parity and framing checks, one po_flag pulse per frame.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a falling edge on the synchronised line
//   ST_START  | start bit; a majority of 1 at mid-bit is treated as a glitch
//   ST_DATA   | DATA_W data bits, LSB first, shifted in at mid-bit
//   ST_PARITY | parity bit compared against the received data
//   ST_STOP   | stop bit(s); frame is delivered just after mid of the last one
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              po_flag,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int BAUD_CNT = baud_cnt_calc(CLK_FREQ, BAUD);
  localparam int IW       = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic ODD_FLIP = (PARITY == PARITY_ODD);

  logic rx_m, rx_ss, rx_s;
  logic fall;
  logic smp_m1, smp_mid, smp_p1, bit_end;
  logic s_m1, s_mid, maj;

  rx_state_t state, state_nxt;
  logic [IW-1:0]     bit_idx;
  logic              stop_idx;
  logic              last_stop;
  logic [DATA_W-1:0] shreg;
  logic              perr_acc, ferr_acc;

  logic clr_cnt, idx_clr, idx_inc, shift_en, par_chk, stop_smp, stop_next, finish;

  // two synchroniser flops plus one history flop for edge detection; idle-high reset
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m  <= 1'b1;
      rx_ss <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_m  <= rx;
      rx_ss <= rx_m;
      rx_s  <= rx_ss;
    end
  end

  assign fall = rx_s & ~rx_ss;

  uart_baud_tick #(
    .BAUD_CNT(BAUD_CNT)
  ) u_baud_tick (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .clr     (clr_cnt),
    .smp_m1  (smp_m1),
    .smp_mid (smp_mid),
    .smp_p1  (smp_p1),
    .bit_end (bit_end)
  );

  // third vote is the live sample, so the majority is valid at MID+1
  assign maj       = maj3(s_m1, s_mid, rx_s);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign busy      = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode and datapath strobes
  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_smp  = 1'b0;
    stop_next = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_nxt = ST_START;
          clr_cnt   = 1'b1;
        end
      end
      ST_START: begin
        if (smp_p1 && maj) begin
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          state_nxt = ST_DATA;
          idx_clr   = 1'b1;
        end
      end
      ST_DATA: begin
        shift_en = smp_p1;
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        par_chk = smp_p1;
        if (bit_end) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        stop_smp = smp_p1;
        if (smp_p1 && last_stop) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          stop_next = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // sample capture, shifter, error accumulators and registered outputs
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      s_m1       <= 1'b1;
      s_mid      <= 1'b1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      po_flag    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      po_flag <= 1'b0;
      if (smp_m1)  s_m1  <= rx_s;
      if (smp_mid) s_mid <= rx_s;
      if (clr_cnt) begin
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
        stop_idx <= 1'b0;
      end
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (idx_inc) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en)  shreg    <= {maj, shreg[DATA_W-1:1]};
      if (par_chk)   perr_acc <= maj ^ (^shreg) ^ ODD_FLIP;
      if (stop_smp)  ferr_acc <= ferr_acc | ~maj;
      if (stop_next) stop_idx <= 1'b1;
      if (finish) begin
        po_flag    <= 1'b1;
        rx_data    <= shreg;
        parity_err <= perr_acc;
        frame_err  <= ferr_acc | ~maj;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three instances (8E1, 8N1, 7O2) driven in parallel.
// Frames are queued as expected results when sent; per-instance monitors pop
// and compare on every po_flag.
module tb_uart_rx_core;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int MID      = B / 2;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  int dw_c [3] = '{8, 8, 7};
  int par_c[3] = '{2, 0, 1};
  int sb_c [3] = '{1, 1, 2};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n  [3];
  logic rx_line[3];
  logic po[3], pe[3], fe[3], bz[3];
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int checks = 0;
  int errors = 0;
  exp_t q0[$], q1[$], q2[$];

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_dut0 (
    .sclk(clk), .rst_n(rst_n[0]), .rx(rx_line[0]), .rx_data(d0), .po_flag(po[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));
  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_dut1 (
    .sclk(clk), .rst_n(rst_n[1]), .rx(rx_line[1]), .rx_data(d1), .po_flag(po[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));
  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .sclk(clk), .rst_n(rst_n[2]), .rx(rx_line[2]), .rx_data(d2), .po_flag(po[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [8:0] out_data(input int id);
    case (id)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b0, d2};
    endcase
  endfunction

  task automatic chk_cleared(input int id, input string name);
    chk($sformatf("%s_data_dut%0d", name, id), 32'(out_data(id)), 32'd0);
    chk($sformatf("%s_flags_dut%0d", name, id), {28'd0, po[id], pe[id], fe[id], bz[id]}, 32'd0);
  endtask

  // reference model: what the frame on the line should deliver
  function automatic exp_t model(input int id, input int data, input bit par_flip, input int stop_zero);
    exp_t e;
    e.data = 9'(data & ((1 << dw_c[id]) - 1));
    e.perr = (par_c[id] != 0) && par_flip;
    e.ferr = ((stop_zero & ((1 << sb_c[id]) - 1)) != 0);
    return e;
  endfunction

  task automatic push_exp(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_flag(input int id, input logic [8:0] d, input logic p, input logic f);
    exp_t e;
    bit   have;
    have = 0;
    e    = '0;
    case (id)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_flag dut%0d got data=%h perr=%b ferr=%b want no flag", id, d, p, f);
    end else if (d !== e.data || p !== e.perr || f !== e.ferr) begin
      errors++;
      $display("FAIL frame dut%0d got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
               id, d, p, f, e.data, e.perr, e.ferr);
    end
  endtask

  always @(negedge clk) if (po[0] === 1'b1) check_flag(0, {1'b0, d0}, pe[0], fe[0]);
  always @(negedge clk) if (po[1] === 1'b1) check_flag(1, {1'b0, d1}, pe[1], fe[1]);
  always @(negedge clk) if (po[2] === 1'b1) check_flag(2, {2'b0, d2}, pe[2], fe[2]);

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int id, input int n);
    rx_line[id] = 1'b1;
    wait_cyc(n);
  endtask

  // drive one frame; optional inverted window around MID of one data bit,
  // optional abort (line released high) after abort_at cycles
  task automatic send(input int id, input int data, input bit par_flip, input int stop_zero,
                      input int glitch_bit, input int glitch_len, input int abort_at);
    logic       bits[$];
    logic [8:0] m;
    logic       pb;
    int n, gb, lo;
    m = 9'(data & ((1 << dw_c[id]) - 1));
    bits.push_back(1'b0);
    for (int i = 0; i < dw_c[id]; i++) bits.push_back(m[i]);
    if (par_c[id] != 0) begin
      pb = (par_c[id] == 2) ? ^m : ~^m;
      bits.push_back(pb ^ par_flip);
    end
    for (int i = 0; i < sb_c[id]; i++) bits.push_back(((stop_zero >> i) & 1) != 0 ? 1'b0 : 1'b1);
    gb = glitch_bit + 1;
    lo = MID - glitch_len / 2;
    n  = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < B; c++) begin
        if (abort_at > 0 && n == abort_at) begin
          rx_line[id] = 1'b1;
          return;
        end
        rx_line[id] = bits[b] ^ (glitch_len > 0 && b == gb && c >= lo && c < lo + glitch_len);
        wait_cyc(1);
        n++;
      end
    end
  endtask

  task automatic rand_frame(input int id);
    int data, sz;
    bit pf;
    data = int'($urandom_range(0, 511));
    pf   = ($urandom_range(0, 3) == 0);
    sz   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, (1 << sb_c[id]) - 1)) : 0;
    push_exp(id, model(id, data, pf, sz));
    send(id, data, pf, sz, -1, 0, 0);
    if (((sz >> (sb_c[id] - 1)) & 1) != 0) idle(id, int'($urandom_range(8, 40)));
    else                                    idle(id, int'($urandom_range(0, 40)));
  endtask

  // 8E1: good and bad parity back-to-back, then random traffic
  task automatic seq0();
    push_exp(0, model(0, 'hA3, 0, 0));
    send(0, 'hA3, 0, 0, -1, 0, 0);
    push_exp(0, model(0, 'hA3, 1, 0));
    send(0, 'hA3, 1, 0, -1, 0, 0);
    idle(0, 10);
    for (int k = 0; k < 5; k++) rand_frame(0);
  endtask

  // 8N1: back-to-back, start glitch, break, majority vote, reset mid-frame
  task automatic seq1();
    push_exp(1, model(1, 'h55, 0, 0));
    send(1, 'h55, 0, 0, -1, 0, 0);
    push_exp(1, model(1, 'hA3, 0, 0));
    send(1, 'hA3, 0, 0, -1, 0, 0);
    idle(1, 20);

    rx_line[1] = 1'b0;
    wait_cyc(50);
    chk("glitch_busy_high", 32'(bz[1]), 32'd1);
    wait_cyc(50);
    rx_line[1] = 1'b1;
    wait_cyc(200);
    chk("glitch_busy_low", 32'(bz[1]), 32'd0);
    idle(1, 20);

    push_exp(1, model(1, 'h3C, 0, 1));
    send(1, 'h3C, 0, 1, -1, 0, 0);
    rx_line[1] = 1'b0;
    wait_cyc(3 * 10 * B);
    chk("break_idle", 32'(bz[1]), 32'd0);
    idle(1, B);
    push_exp(1, model(1, 'h81, 0, 0));
    send(1, 'h81, 0, 0, -1, 0, 0);

    push_exp(1, model(1, 'h00, 0, 0));
    send(1, 'h00, 0, 0, 3, 1, 0);
    push_exp(1, model(1, 'h08, 0, 0));
    send(1, 'h00, 0, 0, 3, 3, 0);
    idle(1, 10);

    send(1, 'h99, 0, 0, -1, 0, 5 * B + MID);
    rst_n[1] = 1'b0;
    wait_cyc(3);
    chk_cleared(1, "midreset");
    wait_cyc(10);
    rst_n[1] = 1'b1;
    idle(1, 5);
    push_exp(1, model(1, 'h7E, 0, 0));
    send(1, 'h7E, 0, 0, -1, 0, 0);
    idle(1, 5);
    for (int k = 0; k < 2; k++) rand_frame(1);
  endtask

  // 7O2: traffic, reset mid-frame, then recovery frames
  task automatic seq2();
    for (int k = 0; k < 2; k++) rand_frame(2);
    push_exp(2, model(2, 'h5A, 0, 0));
    send(2, 'h5A, 0, 0, -1, 0, 0);
    send(2, 'h33, 0, 0, -1, 0, 5 * B + MID);
    rst_n[2] = 1'b0;
    wait_cyc(3);
    chk_cleared(2, "midreset");
    wait_cyc(10);
    rst_n[2] = 1'b1;
    idle(2, 5);
    push_exp(2, model(2, 'h5A, 0, 0));
    send(2, 'h5A, 0, 0, -1, 0, 0);
    push_exp(2, model(2, 'h15, 1, 2));
    send(2, 'h15, 1, 2, -1, 0, 0);
    idle(2, 20);
    for (int k = 0; k < 3; k++) rand_frame(2);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      rst_n[i]   = 1'b0;
      rx_line[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_cleared(i, "reset");
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    wait_cyc(5);
    fork
      seq0();
      seq1();
      seq2();
    join
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 4 * B) begin
      wait_cyc(1);
      n++;
    end
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_q2", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    errors++;
    $display("FAIL watchdog got=timeout want=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
